key_event_arbiter: RTL and testbench

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_evt_fifo.sv | 55 +++++
 rtl/key_event_arbiter.sv | 140 ++++++++++++++
 tb/tb_key_event_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_pkg : shared defaults, index width and event record for the key arbiter |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package key_pkg;

    localparam int C_KEY_NUM_DEF    = 3;
    localparam int C_FIFO_DEPTH_DEF = 4;
    localparam int C_KEY_IDX_W      = $clog2(C_KEY_NUM_DEF);

    typedef struct packed {
        logic                   rpt;
        logic [C_KEY_IDX_W-1:0] idx;
    } key_evt_t;

    // Modular add for indices already below n, without a divider.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_evt_fifo : synchronous first-word-fall-through event queue              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_evt_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_event_arbiter : round-robin merge of per-key press/repeat pulses into  |
// | one FWFT event stream. Define KEY_ARB_DROP_CNT_EN for the drop counter.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int KEY_NUM    = C_KEY_NUM_DEF,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [KEY_NUM-1:0]         key_evt,
    input  logic [KEY_NUM-1:0]         key_rpt,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(KEY_NUM)-1:0] evt_key,
    output logic                       evt_rpt,
    output logic                       evt_ovf,
    input  logic                       ovf_clr,
    output logic [7:0]                 drop_cnt
);
    localparam int IDX_W = $clog2(KEY_NUM);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic             rpt;
        logic [IDX_W-1:0] idx;
    } evt_t;

    logic [KEY_NUM-1:0] r_pending;
    logic [KEY_NUM-1:0] r_type;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_ovf;

    logic [KEY_NUM-1:0] w_pulse;
    logic [KEY_NUM-1:0] w_gnt_oh;
    logic [KEY_NUM-1:0] w_drop;
    logic               w_gnt_vld;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_cand;
    evt_t               w_push_evt;
    evt_t               w_head_evt;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;

    always_comb begin
        w_pulse   = key_evt | key_rpt;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_gnt_oh  = '0;
        // A full queue blocks the grant even when the head is leaving this cycle.
        for (int i = 0; i < KEY_NUM; i++) begin
            w_cand = IDX_W'(wrap_add(int'(r_rr_ptr), i, KEY_NUM));
            if (!w_full && !w_gnt_vld && r_pending[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        for (int k = 0; k < KEY_NUM; k++) begin
            w_gnt_oh[k] = w_gnt_vld && (w_gnt_idx == IDX_W'(k));
        end
        w_drop         = w_pulse & r_pending & ~w_gnt_oh;
        w_push_evt.rpt = r_type[w_gnt_idx];
        w_push_evt.idx = w_gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_type    <= '0;
            r_rr_ptr  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            // A slot being granted is free again, so a same-cycle pulse refills it.
            for (int k = 0; k < KEY_NUM; k++) begin
                if (w_gnt_oh[k] || !r_pending[k]) begin
                    r_pending[k] <= w_pulse[k];
                    if (w_pulse[k]) r_type[k] <= key_rpt[k];
                end
            end
            if (w_gnt_vld) r_rr_ptr <= IDX_W'(wrap_add(int'(w_gnt_idx), 1, KEY_NUM));
            if (ovf_clr)      r_ovf <= 1'b0;
            else if (|w_drop) r_ovf <= 1'b1;
        end
    end

    assign w_pop = evt_valid && evt_ready;

    key_evt_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_gnt_vld),
        .wdata (w_push_evt),
        .pop   (w_pop),
        .rdata (w_head_evt),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign evt_valid = (w_count != '0);
    assign evt_key   = w_empty ? '0 : w_head_evt.idx;
    assign evt_rpt   = !w_empty && w_head_evt.rpt;
    assign evt_ovf   = r_ovf;

`ifdef KEY_ARB_DROP_CNT_EN
    logic [3:0] w_drop_num;
    logic [8:0] w_drop_sum;
    logic [7:0] r_drop_cnt;

    always_comb begin
        w_drop_num = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            w_drop_num = w_drop_num + 4'(w_drop[k]);
        end
        w_drop_sum = 9'(r_drop_cnt) + 9'(w_drop_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_drop_cnt <= '0;
        else if (ovf_clr)    r_drop_cnt <= '0;
        else if (|w_drop)    r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_event_arbiter : directed table, corner sequences and random traffic |
// | against a queue-based reference model. Revision: 1.0                        |
// +----------------------------------------------------------------------------+
module tb_key_event_arbiter;
    localparam int KN    = 3;
    localparam int DEPTH = 4;
`ifdef KEY_ARB_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KN-1:0] key_evt;
    logic [KN-1:0] key_rpt;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [1:0]    evt_key;
    logic          evt_rpt;
    logic          evt_ovf;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    key_event_arbiter #(.KEY_NUM(KN), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_evt   (key_evt),
        .key_rpt   (key_rpt),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_rpt   (evt_rpt),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int key; bit rpt; } mev_t;
    mev_t m_q[$];
    bit   m_pend[KN];
    bit   m_ptype[KN];
    int   m_rr;
    bit   m_ovf;
    int   m_drops;

    typedef struct {
        logic [KN-1:0] evt;
        logic [KN-1:0] rpt;
        logic          rdy;
        logic          exp_valid;
        int            exp_key;
        logic          exp_rpt;
        logic          exp_ovf;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual %0d, required %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < KN; k++) begin
            m_pend[k]  = 1'b0;
            m_ptype[k] = 1'b0;
        end
        m_rr    = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge worth of behaviour, taken straight from the event rules.
    task automatic model_edge();
        int   g;
        int   ndrop;
        bit   pop;
        mev_t ge;
        pop = (m_q.size() != 0) && evt_ready;
        g   = -1;
        if (m_q.size() < DEPTH) begin
            for (int i = 0; i < KN; i++) begin
                if (m_pend[(m_rr + i) % KN]) begin
                    g = (m_rr + i) % KN;
                    break;
                end
            end
        end
        if (g >= 0) begin
            ge.key = g;
            ge.rpt = m_ptype[g];
        end
        ndrop = 0;
        for (int k = 0; k < KN; k++) begin
            bit p;
            p = key_evt[k] || key_rpt[k];
            if (p && m_pend[k] && k != g) ndrop++;
            else if (k == g || !m_pend[k]) begin
                m_pend[k] = p;
                if (p) m_ptype[k] = key_rpt[k];
            end
        end
        if (pop) m_q.delete(0);
        if (g >= 0) begin
            m_q.push_back(ge);
            m_rr = (g + 1) % KN;
        end
        if (ovf_clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (ndrop > 0) begin
            m_ovf   = 1'b1;
            m_drops = (m_drops + ndrop > 255) ? 255 : m_drops + ndrop;
        end
    endtask

    task automatic model_check();
        bit v;
        v = (m_q.size() != 0);
        chk("m_valid", int'(evt_valid), int'(v));
        chk("m_key",   int'(evt_key),   v ? m_q[0].key : 0);
        chk("m_rpt",   int'(evt_rpt),   v ? int'(m_q[0].rpt) : 0);
        chk("m_ovf",   int'(evt_ovf),   int'(m_ovf));
        chk("m_drop_cnt", int'(drop_cnt), CNT_EN ? m_drops : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        model_check();
    endtask

    task automatic pulse(input logic [KN-1:0] e, input logic [KN-1:0] r);
        key_evt = e;
        key_rpt = r;
        tick();
        key_evt = '0;
        key_rpt = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual time %0t, required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got_key[$];
        int got_rpt[$];
        int exp_order[6];

        tbl[0]  = '{3'b111, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{3'b000, 3'b000, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[2]  = '{3'b000, 3'b000, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[3]  = '{3'b000, 3'b000, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        tbl[4]  = '{3'b000, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[5]  = '{3'b010, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[6]  = '{3'b000, 3'b000, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[8]  = '{3'b001, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[9]  = '{3'b000, 3'b000, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[10] = '{3'b111, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[12] = '{3'b000, 3'b000, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        tbl[13] = '{3'b000, 3'b000, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[14] = '{3'b000, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[15] = '{3'b100, 3'b100, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[16] = '{3'b000, 3'b000, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[17] = '{3'b000, 3'b000, 1'b1, 1'b0, 0, 1'b0, 1'b0};

        rst_n = 1'b0; key_evt = '0; key_rpt = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_key",   int'(evt_key),   0);
        chk("rst_rpt",   int'(evt_rpt),   0);
        chk("rst_ovf",   int'(evt_ovf),   0);
        chk("rst_drop",  int'(drop_cnt),  0);
        @(negedge clk) rst_n = 1'b1;

        // Latency, round-robin order and combined press+repeat
        for (int i = 0; i < 18; i++) begin
            key_evt   = tbl[i].evt;
            key_rpt   = tbl[i].rpt;
            evt_ready = tbl[i].rdy;
            tick();
            key_evt = '0;
            key_rpt = '0;
            chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_key", i),   int'(evt_key),   tbl[i].exp_key);
            chk($sformatf("tbl%0d_rpt", i),   int'(evt_rpt),   int'(tbl[i].exp_rpt));
            chk($sformatf("tbl%0d_ovf", i),   int'(evt_ovf),   int'(tbl[i].exp_ovf));
        end

        // Back-pressure: fill the queue, park two keys in pending, then drain
        evt_ready = 1'b0;
        exp_order = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            pulse(KN'(1 << exp_order[i]), '0);
            tick();
            tick();
        end
        chk("fill_valid", int'(evt_valid), 1);
        chk("fill_head",  int'(evt_key),   0);
        chk("fill_ovf",   int'(evt_ovf),   0);
        evt_ready = 1'b1;
        for (int c = 0; c < 30 && got_key.size() < 6; c++) begin
            if (evt_valid) begin
                got_key.push_back(int'(evt_key));
                got_rpt.push_back(int'(evt_rpt));
            end
            tick();
        end
        chk("drain_count", got_key.size(), 6);
        for (int i = 0; i < 6 && i < got_key.size(); i++) begin
            chk($sformatf("drain%0d_key", i), got_key[i], exp_order[i]);
            chk($sformatf("drain%0d_rpt", i), got_rpt[i], 0);
        end

        // Drops while the queue is full, clear priority and saturation
        evt_ready = 1'b0;
        pulse(3'b111, '0);
        repeat (3) tick();
        pulse(3'b010, '0);
        tick();
        pulse(3'b001, '0);
        tick();
        chk("nodrop_ovf", int'(evt_ovf), 0);
        pulse(3'b001, '0);
        chk("drop1_ovf", int'(evt_ovf), 1);
        chk("drop1_cnt", int'(drop_cnt), CNT_EN ? 1 : 0);
        pulse(3'b001, '0);
        chk("drop2_cnt", int'(drop_cnt), CNT_EN ? 2 : 0);
        ovf_clr = 1'b1;
        pulse(3'b001, '0);
        ovf_clr = 1'b0;
        chk("clrpri_ovf", int'(evt_ovf), 0);
        chk("clrpri_cnt", int'(drop_cnt), 0);
        pulse(3'b001, '0);
        chk("drop3_cnt", int'(drop_cnt), CNT_EN ? 1 : 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", int'(evt_ovf), 0);
        chk("clr_cnt", int'(drop_cnt), 0);
        key_evt = 3'b001;
        repeat (260) tick();
        key_evt = '0;
        chk("sat_cnt", int'(drop_cnt), CNT_EN ? 255 : 0);
        chk("sat_ovf", int'(evt_ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Reset with three queued and two pending events
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && evt_valid; c++) tick();
        chk("pre_rst_empty", int'(evt_valid), 0);
        evt_ready = 1'b0;
        pulse(3'b111, '0);
        repeat (3) tick();
        pulse(3'b011, '0);
        chk("pre_rst_valid", int'(evt_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(evt_valid), 0);
        chk("async_rst_key",   int'(evt_key),   0);
        chk("async_rst_rpt",   int'(evt_rpt),   0);
        model_reset();
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("post_rst_valid", int'(evt_valid), 0);
        end

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < KN; k++) begin
                key_evt[k] = ($urandom_range(0, 5) == 0);
                key_rpt[k] = ($urandom_range(0, 9) == 0);
            end
            evt_ready = ((c % 200) < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 40) == 0);
            tick();
        end
        key_evt = '0;
        key_rpt = '0;
        ovf_clr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
